// File: rtl/html_char_tokenizer.sv
// html_char_tokenizer: pulls chars over a 1-cycle char_request handshake, tokenizes restricted HTML, emits valid/ready tokens (type/id/value), busy/done/error status
module html_char_tokenizer #(
  parameter int CHAR_W   = 8,
  parameter int NAME_MAX = 10
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_start,
  output logic              o_char_request,
  input  logic [CHAR_W-1:0] i_char_in,
  input  logic              i_source_finished,
  output logic              o_token_valid,
  input  logic              i_token_ready,
  output logic [2:0]        o_token_type,
  output logic [1:0]        o_token_id,
  output logic [CHAR_W-1:0] o_token_value,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error
);
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_PROC, S_EMIT, S_DONE, S_ERROR} state_t;
  typedef enum logic [2:0] {C_TEXT, C_TAG_OPEN, C_TAG_NAME, C_ATTR_SKIP, C_ATTR_NAME, C_ATTR_VALUE, C_CLOSE_NAME} ctx_t;
  localparam int LEN_W = $clog2(NAME_MAX + 1);
  localparam int BUF_W = NAME_MAX * CHAR_W;
  localparam logic [2:0] T_OPEN = 3'd1, T_ATTR = 3'd2, T_END = 3'd3, T_CLOSE = 3'd4, T_TEXT = 3'd5, T_EOS = 3'd6;
  localparam logic [CHAR_W-1:0] K_LT = CHAR_W'(8'h3C), K_GT = CHAR_W'(8'h3E), K_SL = CHAR_W'(8'h2F);
  localparam logic [CHAR_W-1:0] K_SP = CHAR_W'(8'h20), K_EQ = CHAR_W'(8'h3D), K_D0 = CHAR_W'(8'h30);
  state_t r_state, w_state_nxt;
  ctx_t r_ctx, w_ctx_nxt;
  logic [BUF_W-1:0] r_name, w_name_nxt;
  logic [LEN_W-1:0] r_len, w_len_nxt;
  logic r_ovf, w_ovf_nxt, r_pend, w_pend_nxt, r_fin, w_app, w_clr;
  logic [CHAR_W-1:0] r_char, r_tok_value, w_value_nxt;
  logic [2:0] r_tok_type, w_type_nxt;
  logic [1:0] r_tok_id, w_id_nxt, w_tag_id, w_attr_id;
  logic w_letter, w_digit, w_print, w_eos, w_full;
  assign w_letter = (r_char >= CHAR_W'(8'h61) && r_char <= CHAR_W'(8'h7A)) || (r_char >= CHAR_W'(8'h41) && r_char <= CHAR_W'(8'h5A));
  assign w_digit  = r_char >= K_D0 && r_char <= CHAR_W'(8'h39);
  assign w_print  = r_char >= K_SP && r_char <= CHAR_W'(8'h7E);
  assign w_eos    = r_fin || r_char == '0;
  assign w_full   = r_len == LEN_W'(NAME_MAX);
  assign w_tag_id = r_ovf ? 2'd0 :
                    (r_len == LEN_W'(4) && r_name[31:0] == "body") ? 2'd1 :
                    (r_len == LEN_W'(1) && r_name[7:0] == "p") ? 2'd2 : 2'd0;
  assign w_attr_id = r_ovf ? 2'd0 :
                     (r_len == LEN_W'(5) && r_name[39:0] == "color") ? 2'd1 :
                     (r_len == LEN_W'(4) && r_name[31:0] == "size") ? 2'd2 :
                     (r_len == LEN_W'(10) && r_name[79:0] == "background") ? 2'd3 : 2'd0;
  // newest char shifts in at the low byte so a name of length n sits in the low n bytes
  assign w_name_nxt = w_clr ? '0 : w_app ? {r_name[BUF_W-CHAR_W-1:0], r_char} : r_name;
  assign w_len_nxt  = w_clr ? '0 : (w_app && !w_full) ? r_len + 1'b1 : r_len;
  assign w_ovf_nxt  = w_clr ? 1'b0 : r_ovf | (w_app && w_full);
  always_comb begin
    w_state_nxt = r_state;
    w_ctx_nxt   = r_ctx;
    w_app       = 1'b0;
    w_clr       = 1'b0;
    w_pend_nxt  = r_pend;
    w_type_nxt  = r_tok_type;
    w_id_nxt    = r_tok_id;
    w_value_nxt = r_tok_value;
    case (r_state)
      S_IDLE: w_state_nxt = i_start ? S_REQ : S_IDLE;
      S_REQ:  w_state_nxt = S_WAIT;
      S_WAIT: w_state_nxt = S_PROC;
      S_PROC: begin
        w_state_nxt = S_REQ;
        if (w_eos) begin
          if (r_ctx == C_TEXT) begin w_state_nxt = S_EMIT; w_type_nxt = T_EOS; w_id_nxt = '0; w_value_nxt = '0; end
          else w_state_nxt = S_ERROR;
        end else
          case (r_ctx)
            C_TEXT:
              if (r_char == K_LT) w_ctx_nxt = C_TAG_OPEN;
              else if (w_print) begin w_state_nxt = S_EMIT; w_type_nxt = T_TEXT; w_id_nxt = '0; w_value_nxt = r_char; end
            C_TAG_OPEN:
              if (r_char == K_SL) w_ctx_nxt = C_CLOSE_NAME;
              else begin w_app = 1'b1; w_ctx_nxt = C_TAG_NAME; end
            C_TAG_NAME:
              if (r_char == K_SP || r_char == K_GT) begin
                w_state_nxt = S_EMIT; w_type_nxt = T_OPEN; w_id_nxt = w_tag_id; w_value_nxt = '0; w_clr = 1'b1;
                w_pend_nxt = r_char == K_GT;
                w_ctx_nxt = r_char == K_GT ? C_TEXT : C_ATTR_SKIP;
              end else w_app = 1'b1;
            C_ATTR_SKIP:
              if (r_char == K_GT) begin w_state_nxt = S_EMIT; w_type_nxt = T_END; w_id_nxt = '0; w_value_nxt = '0; w_ctx_nxt = C_TEXT; end
              else if (w_letter) begin w_app = 1'b1; w_ctx_nxt = C_ATTR_NAME; end
              else if (r_char != K_SP) w_state_nxt = S_ERROR;
            C_ATTR_NAME:
              if (r_char == K_EQ) w_ctx_nxt = C_ATTR_VALUE;
              else if (r_char == K_SP || r_char == K_GT) w_state_nxt = S_ERROR;
              else w_app = 1'b1;
            C_ATTR_VALUE:
              if (w_digit) begin
                w_state_nxt = S_EMIT; w_type_nxt = T_ATTR; w_id_nxt = w_attr_id; w_value_nxt = r_char - K_D0; w_clr = 1'b1;
                w_ctx_nxt = C_ATTR_SKIP;
              end else w_state_nxt = S_ERROR;
            C_CLOSE_NAME:
              if (r_char == K_GT) begin
                w_state_nxt = S_EMIT; w_type_nxt = T_CLOSE; w_id_nxt = w_tag_id; w_value_nxt = '0; w_clr = 1'b1; w_ctx_nxt = C_TEXT;
              end else w_app = 1'b1;
            default: w_state_nxt = S_ERROR;
          endcase
      end
      S_EMIT:
        if (i_token_ready) begin
          if (r_pend) begin w_pend_nxt = 1'b0; w_type_nxt = T_END; w_id_nxt = '0; w_value_nxt = '0; end
          else w_state_nxt = r_tok_type == T_EOS ? S_DONE : S_REQ;
        end
      default: w_state_nxt = r_state;
    endcase
  end
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) begin
      r_state <= S_IDLE;
      r_ctx <= C_TEXT;
      r_name <= '0;
      r_len <= '0;
      r_ovf <= 1'b0;
      r_pend <= 1'b0;
      r_char <= '0;
      r_fin <= 1'b0;
      r_tok_type <= '0;
      r_tok_id <= '0;
      r_tok_value <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ctx <= w_ctx_nxt;
      r_name <= w_name_nxt;
      r_len <= w_len_nxt;
      r_ovf <= w_ovf_nxt;
      r_pend <= w_pend_nxt;
      r_tok_type <= w_type_nxt;
      r_tok_id <= w_id_nxt;
      r_tok_value <= w_value_nxt;
      if (r_state == S_WAIT) begin
        r_char <= i_char_in;
        r_fin <= i_source_finished;
      end
    end
  assign o_char_request = r_state == S_REQ;
  assign o_token_valid  = r_state == S_EMIT;
  assign o_busy         = r_state inside {S_REQ, S_WAIT, S_PROC, S_EMIT};
  assign o_done         = r_state == S_DONE;
  assign o_error        = r_state == S_ERROR;
  assign o_token_type   = r_tok_type;
  assign o_token_id     = r_tok_id;
  assign o_token_value  = r_tok_value;
endmodule
